// File: rtl/fetch_queue.sv
// Instruction fetch unit: PC, read-only instruction ROM and a FIFO of {instr, pc+4} entries.
// Optional macro FQ_MISALIGN_CHK_EN traps misaligned redirect targets into a sticky FAULT state.
module fetch_queue #(
  parameter int              XLEN       = 32,
  parameter int              IMEM_DEPTH = 32,
  parameter int              FQ_DEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        redirect_valid,
  input  logic [XLEN-1:0]             redirect_pc,
  input  logic                        deq_ready,
  output logic                        deq_valid,
  output logic [31:0]                 deq_instr,
  output logic [XLEN-1:0]             deq_npc,
  output logic [$clog2(FQ_DEPTH):0]   fq_count,
  output logic                        fault,
  output logic [XLEN-1:0]             fault_pc
);

  localparam int IW = $clog2(IMEM_DEPTH);
  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [PW-1:0]   head_reg, head_next;
  logic [PW-1:0]   tail_reg, tail_next;
  logic [CW-1:0]   count_reg, count_next;
  logic            fault_reg, fault_next;
  logic [XLEN-1:0] fault_pc_reg, fault_pc_next;

  // ROM contents are a pure function of the word index
  logic [31:0] imem [IMEM_DEPTH];
  generate
    for (genvar gi = 0; gi < IMEM_DEPTH; gi++) begin : g_imem
      assign imem[gi] = 32'hA000_0000 + 32'(gi);
    end
  endgenerate

  logic [IW-1:0] imem_idx;
  logic [31:0]   fetch_instr;
  logic [XLEN-1:0] pc_plus4;

  assign imem_idx    = pc_reg[IW+1:2];
  assign fetch_instr = imem[imem_idx];
  assign pc_plus4    = pc_reg + XLEN'(4);

  logic [31:0]     q_instr [FQ_DEPTH];
  logic [XLEN-1:0] q_npc   [FQ_DEPTH];

  logic is_run;
  logic q_full;
  logic do_deq;
  logic do_fetch;
  logic redirect_bad;
  logic [XLEN-1:0] redirect_target;

  assign is_run          = (state_reg == RUN);
  assign q_full          = (count_reg == CW'(FQ_DEPTH));
  assign deq_valid       = is_run && (count_reg != '0);
  assign do_deq          = deq_valid && deq_ready && !redirect_valid;
  assign do_fetch        = is_run && !redirect_valid && (!q_full || do_deq);
  assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

`ifdef FQ_MISALIGN_CHK_EN
  assign redirect_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign redirect_bad = 1'b0;
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    head_next     = head_reg;
    tail_next     = tail_reg;
    count_next    = count_reg;
    fault_next    = fault_reg;
    fault_pc_next = fault_pc_reg;
    case (state_reg)
      RUN: begin
        if (redirect_valid) begin
          head_next  = '0;
          tail_next  = '0;
          count_next = '0;
          if (redirect_bad) begin
            // pc is left untouched so the faulting context stays visible
            state_next    = FAULT;
            fault_next    = 1'b1;
            fault_pc_next = redirect_pc;
          end else begin
            pc_next = redirect_target;
          end
        end else begin
          if (do_fetch) begin
            tail_next = tail_reg + PW'(1);
            pc_next   = pc_plus4;
          end
          if (do_deq) begin
            head_next = head_reg + PW'(1);
          end
          count_next = count_reg + CW'(do_fetch) - CW'(do_deq);
        end
      end
      FAULT: begin
        state_next = FAULT;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= RUN;
      pc_reg       <= RESET_PC;
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      fault_reg    <= 1'b0;
      fault_pc_reg <= '0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      count_reg    <= count_next;
      fault_reg    <= fault_next;
      fault_pc_reg <= fault_pc_next;
    end
  end

  // Entry storage needs no reset: occupancy is tracked by count_reg alone
  always_ff @(posedge clk) begin
    if (rst_n && do_fetch) begin
      q_instr[tail_reg] <= fetch_instr;
      q_npc[tail_reg]   <= pc_plus4;
    end
  end

  assign deq_instr = deq_valid ? q_instr[head_reg] : 32'h0;
  assign deq_npc   = deq_valid ? q_npc[head_reg]   : '0;
  assign fq_count  = count_reg;

`ifdef FQ_MISALIGN_CHK_EN
  assign fault    = fault_reg;
  assign fault_pc = fault_pc_reg;
`else
  assign fault    = 1'b0;
  assign fault_pc = '0;
  logic unused_fault_state;
  assign unused_fault_state = fault_reg ^ (^fault_pc_reg);
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, hand-written redirect/fault sequence,
// then random traffic against a queue-based reference model.
module tb_fetch_queue;
  localparam int XLEN = 32;
  localparam int IMEM_DEPTH = 32;
  localparam int FQ_DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            deq_ready = 1'b0;
  logic            deq_valid;
  logic [31:0]     deq_instr;
  logic [XLEN-1:0] deq_npc;
  logic [2:0]      fq_count;
  logic            fault;
  logic [XLEN-1:0] fault_pc;

  int checks = 0;
  int failures = 0;

  fetch_queue #(.XLEN(XLEN), .IMEM_DEPTH(IMEM_DEPTH), .FQ_DEPTH(FQ_DEPTH), .RESET_PC('0)) dut (
    .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .deq_ready(deq_ready), .deq_valid(deq_valid), .deq_instr(deq_instr), .deq_npc(deq_npc),
    .fq_count(fq_count), .fault(fault), .fault_pc(fault_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        rv;
    logic [31:0] rpc;
    logic        dr;
    logic        chk;
    logic        v;
    logic [31:0] instr;
    logic [31:0] npc;
    int          cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic rv, input logic [31:0] rpc, input logic dr,
                     input logic c, input logic v, input logic [31:0] instr,
                     input logic [31:0] npc, input int cnt);
    vec_t t;
    t.rst_n = r; t.rv = rv; t.rpc = rpc; t.dr = dr; t.chk = c;
    t.v = v; t.instr = instr; t.npc = npc; t.cnt = cnt;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s [%0d] actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  // Reference model state
  logic [31:0]     m_instr[$];
  logic [XLEN-1:0] m_npc[$];
  logic [XLEN-1:0] m_pc;
  logic            m_fault;
  logic [XLEN-1:0] m_fault_pc;

  task automatic model_step(input logic r, input logic rv, input logic [XLEN-1:0] rpc, input logic dr);
    bit deq, fetch;
    if (!r) begin
      m_instr.delete(); m_npc.delete();
      m_pc = '0; m_fault = 0; m_fault_pc = '0;
    end else if (!m_fault) begin
      if (rv) begin
        m_instr.delete(); m_npc.delete();
`ifdef FQ_MISALIGN_CHK_EN
        if (rpc % 4 != 0) begin
          m_fault = 1; m_fault_pc = rpc;
        end else
`endif
          m_pc = rpc - (rpc % 4);
      end else begin
        deq = (m_instr.size() != 0) && dr;
        fetch = (m_instr.size() < FQ_DEPTH) || deq;
        if (deq) begin
          void'(m_instr.pop_front()); void'(m_npc.pop_front());
        end
        if (fetch) begin
          m_instr.push_back(32'hA000_0000 + 32'((m_pc / 4) % IMEM_DEPTH));
          m_npc.push_back(m_pc + 4);
          m_pc = m_pc + 4;
        end
      end
    end
  endtask

  initial begin
    // Directed table: each row drives inputs, then checks outputs before that row's edge
    add(0,0,0,1, 0, 0,0,0,0);
    add(0,0,0,1, 1, 0,0,0,0);
    add(1,0,0,1, 1, 0,0,0,0);
    add(1,0,0,1, 1, 1,32'hA000_0000,32'h4,1);
    add(1,0,0,1, 1, 1,32'hA000_0001,32'h8,1);
    add(1,0,0,1, 1, 1,32'hA000_0002,32'hC,1);
    add(0,0,0,0, 0, 0,0,0,0);
    add(1,0,0,0, 1, 0,0,0,0);
    add(1,0,0,0, 1, 1,32'hA000_0000,32'h4,1);
    add(1,0,0,0, 1, 1,32'hA000_0000,32'h4,2);
    add(1,0,0,0, 1, 1,32'hA000_0000,32'h4,3);
    for (int i = 0; i < 6; i++) add(1,0,0,0, 1, 1,32'hA000_0000,32'h4,4);
    add(1,0,0,1, 1, 1,32'hA000_0000,32'h4,4);
    add(1,0,0,1, 1, 1,32'hA000_0001,32'h8,4);
    add(1,0,0,1, 1, 1,32'hA000_0002,32'hC,4);
    add(1,0,0,1, 1, 1,32'hA000_0003,32'h10,4);
    add(1,0,0,1, 1, 1,32'hA000_0004,32'h14,4);
    add(1,1,32'h20,1, 1, 1,32'hA000_0005,32'h18,4);
    add(1,0,0,1, 1, 0,0,0,0);
    add(1,0,0,1, 1, 1,32'hA000_0008,32'h24,1);
    add(1,1,32'h7C,1, 1, 1,32'hA000_0009,32'h28,1);
    add(1,0,0,1, 1, 0,0,0,0);
    add(1,0,0,1, 1, 1,32'hA000_001F,32'h80,1);
    add(1,0,0,1, 1, 1,32'hA000_0000,32'h84,1);
    add(1,1,32'h0,0, 1, 1,32'hA000_0001,32'h88,1);
    add(1,0,0,0, 1, 0,0,0,0);
    add(1,0,0,0, 1, 1,32'hA000_0000,32'h4,1);
    add(1,0,0,0, 1, 1,32'hA000_0000,32'h4,2);
    add(0,0,0,0, 1, 1,32'hA000_0000,32'h4,3);
    add(1,0,0,1, 1, 0,0,0,0);
    add(1,0,0,1, 1, 1,32'hA000_0000,32'h4,1);
    add(1,0,0,1, 1, 1,32'hA000_0001,32'h8,1);
    add(1,0,0,1, 1, 1,32'hA000_0002,32'hC,1);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n; redirect_valid = vecs[i].rv;
      redirect_pc = vecs[i].rpc; deq_ready = vecs[i].dr;
      #1;
      if (vecs[i].chk) begin
        check("deq_valid", i, 64'(deq_valid), 64'(vecs[i].v));
        check("deq_instr", i, 64'(deq_instr), 64'(vecs[i].instr));
        check("deq_npc", i, 64'(deq_npc), 64'(vecs[i].npc));
        check("fq_count", i, 64'(fq_count), 64'(vecs[i].cnt));
        check("fault", i, 64'(fault), 64'(0));
        $display("vec %0d: v=%0b instr=%h npc=%h cnt=%0d", i, deq_valid, deq_instr, deq_npc, fq_count);
      end
    end

    // Redirect to a misaligned target (queue holds A3, pc=0x10 here)
    @(negedge clk);
    redirect_valid = 1; redirect_pc = 32'h22; deq_ready = 1;
    @(negedge clk);
    redirect_valid = 0; #1;
`ifdef FQ_MISALIGN_CHK_EN
    for (int k = 0; k < 5; k++) begin
      check("mis_fault", k, 64'(fault), 64'(1));
      check("mis_fault_pc", k, 64'(fault_pc), 64'(32'h22));
      check("mis_valid", k, 64'(deq_valid), 64'(0));
      check("mis_count", k, 64'(fq_count), 64'(0));
      $display("misalign %0d: fault=%0b fault_pc=%h v=%0b", k, fault, fault_pc, deq_valid);
      @(negedge clk);
      redirect_valid = 1; redirect_pc = 32'h40; #1;
    end
`else
    check("mis_valid0", 0, 64'(deq_valid), 64'(0));
    check("mis_count0", 0, 64'(fq_count), 64'(0));
    check("mis_fault", 0, 64'(fault), 64'(0));
    @(negedge clk); #1;
    check("mis_valid1", 1, 64'(deq_valid), 64'(1));
    check("mis_instr", 1, 64'(deq_instr), 64'(32'hA000_0008));
    check("mis_npc", 1, 64'(deq_npc), 64'(32'h24));
    check("mis_fault_pc", 1, 64'(fault_pc), 64'(0));
    $display("misalign: v=%0b instr=%h npc=%h fault=%0b", deq_valid, deq_instr, deq_npc, fault);
`endif

    // Random traffic against the reference model
    @(negedge clk);
    rst_n = 0; redirect_valid = 0; deq_ready = 0;
    model_step(0, 0, '0, 0);
    for (int n = 0; n < 3000; n++) begin
      logic r, rv, dr;
      logic [XLEN-1:0] rpc;
      @(negedge clk); #1;
      check("rnd_valid", n, 64'(deq_valid), 64'(m_instr.size() != 0 && !m_fault));
      check("rnd_count", n, 64'(fq_count), 64'(m_instr.size()));
      check("rnd_instr", n, 64'(deq_instr), 64'((m_instr.size() != 0 && !m_fault) ? m_instr[0] : 32'h0));
      check("rnd_npc", n, 64'(deq_npc), 64'((m_npc.size() != 0 && !m_fault) ? m_npc[0] : '0));
      check("rnd_fault", n, 64'(fault), 64'(m_fault));
      check("rnd_fault_pc", n, 64'(fault_pc), 64'(m_fault_pc));
      r  = ($urandom_range(0, 99) >= 2);
      rv = ($urandom_range(0, 99) < 8);
      dr = ($urandom_range(0, 99) < 70);
      case ($urandom_range(0, 9))
        0:       rpc = 32'hFFFF_FFF8;
        1:       rpc = 32'($urandom_range(0, 255));
        default: rpc = 32'($urandom_range(0, 63)) * 4;
      endcase
      rst_n = r; redirect_valid = rv; redirect_pc = rpc; deq_ready = dr;
      model_step(r, rv, rpc, dr);
      if (n % 100 == 0)
        $display("rnd %0d: v=%0b instr=%h npc=%h cnt=%0d fault=%0b", n, deq_valid, deq_instr, deq_npc, fq_count, fault);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
